// File: rtl/dma_burst_sequencer_if.sv
// Bus bundle between the DMA stream/arbiter side and the AHB burst sequencer.
// The master modport is the sequencer's view; slave is the environment driving it.
interface dma_burst_sequencer_if #(
  parameter int ndt_w  = 18,
  parameter int addr_w = 32
);
  logic              i_master_en;
  logic [addr_w-1:0] i_addr;
  logic              i_inc;
  logic [1:0]        i_size;
  logic [1:0]        i_burst;
  logic [ndt_w-1:0]  i_ndt;
  logic              i_hready;
  logic              i_hresp;
  logic [addr_w-1:0] o_haddr;
  logic [1:0]        o_htrans;
  logic [2:0]        o_hsize;
  logic [2:0]        o_hburst;
  logic              o_master_ready;
  logic              o_beat_done;
  logic              o_burst_done;
  logic [4:0]        o_burst_beats;
  logic              o_error;

  modport master (
    input  i_master_en, i_addr, i_inc, i_size, i_burst, i_ndt, i_hready, i_hresp,
    output o_haddr, o_htrans, o_hsize, o_hburst, o_master_ready,
           o_beat_done, o_burst_done, o_burst_beats, o_error
  );

  modport slave (
    output i_master_en, i_addr, i_inc, i_size, i_burst, i_ndt, i_hready, i_hresp,
    input  o_haddr, o_htrans, o_hsize, o_hburst, o_master_ready,
           o_beat_done, o_burst_done, o_burst_beats, o_error
  );
endinterface

// File: rtl/dma_burst_sequencer.sv
// AHB burst sequencer: latches the granted stream's parameters, issues one
// INCR burst (or a single when the burst cannot be used) and reports beat/burst events.
module dma_burst_sequencer #(
  parameter int ndt_w  = 18,
  parameter int addr_w = 32
) (
  input  logic                 i_clk,
  input  logic                 i_nreset,
  dma_burst_sequencer_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST_DATA} state_t;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  state_t            r_state, w_next_state;
  logic [addr_w-1:0] r_haddr;
  logic [1:0]        r_htrans;
  logic [2:0]        r_hsize, r_hburst;
  logic [1:0]        r_size;
  logic              r_inc;
  logic [4:0]        r_beats, r_beats_left, r_burst_beats;
  logic              r_dphase, r_cancel;
  logic              r_beat_done, r_burst_done, r_error;

  logic [1:0]  w_size_eff;
  logic [4:0]  w_req_beats, w_beats;
  logic [2:0]  w_req_hburst, w_hburst;
  logic [10:0] w_span;
  logic        w_degrade, w_start, w_accept, w_last_beat;
  logic        w_err_wait, w_err_done, w_data_done;

  assign w_size_eff = (bus.i_size == 2'd3) ? 2'd2 : bus.i_size;

  always_comb begin
    w_req_beats  = 5'd1;
    w_req_hburst = 3'b000;
    case (bus.i_burst)
      2'd1:    begin w_req_beats = 5'd4;  w_req_hburst = 3'b011; end
      2'd2:    begin w_req_beats = 5'd8;  w_req_hburst = 3'b101; end
      2'd3:    begin w_req_beats = 5'd16; w_req_hburst = 3'b111; end
      default: begin w_req_beats = 5'd1;  w_req_hburst = 3'b000; end
    endcase
  end

  // A burst must neither overrun the remaining items nor cross a 1 KB boundary.
  assign w_span    = {1'b0, bus.i_addr[9:0]} + (11'(w_req_beats) << w_size_eff);
  assign w_degrade = (bus.i_ndt < ndt_w'(w_req_beats)) || !bus.i_inc || (w_span > 11'd1024);
  assign w_beats   = w_degrade ? 5'd1 : w_req_beats;
  assign w_hburst  = w_degrade ? 3'b000 : w_req_hburst;

  assign w_start     = (r_state == S_IDLE) && bus.i_master_en && (bus.i_ndt != '0);
  assign w_accept    = (r_state == S_ADDR) && bus.i_hready && !r_cancel;
  assign w_last_beat = w_accept && (r_beats_left == 5'd1);
  assign w_err_wait  = r_dphase && bus.i_hresp && !bus.i_hready;
  assign w_err_done  = r_dphase && bus.i_hresp && bus.i_hready;
  assign w_data_done = (r_state == S_LAST_DATA) && bus.i_hready && r_dphase && !bus.i_hresp;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk) begin
    if (!i_nreset) r_state <= S_IDLE;
    else           r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (w_start) w_next_state = S_ADDR;
      S_ADDR:      if (w_err_done) w_next_state = S_IDLE;
                   else if (w_last_beat) w_next_state = S_LAST_DATA;
      S_LAST_DATA: if (bus.i_hready) w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_master_ready = (r_state == S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      r_haddr       <= '0;
      r_htrans      <= HT_IDLE;
      r_hsize       <= '0;
      r_hburst      <= '0;
      r_size        <= '0;
      r_inc         <= 1'b0;
      r_beats       <= '0;
      r_beats_left  <= '0;
      r_burst_beats <= '0;
      r_dphase      <= 1'b0;
      r_cancel      <= 1'b0;
      r_beat_done   <= 1'b0;
      r_burst_done  <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_beat_done  <= bus.i_hready && r_dphase && !bus.i_hresp;
      r_burst_done <= w_data_done;
      r_error      <= w_err_done;
      if (bus.i_hready) r_dphase <= w_accept && !w_err_done;
      if (w_data_done)  r_burst_beats <= r_beats;

      if (w_start) begin
        r_haddr      <= bus.i_addr;
        r_htrans     <= HT_NONSEQ;
        r_hsize      <= {1'b0, w_size_eff};
        r_hburst     <= w_hburst;
        r_size       <= w_size_eff;
        r_inc        <= bus.i_inc;
        r_beats      <= w_beats;
        r_beats_left <= w_beats;
        r_cancel     <= 1'b0;
      end else if (w_err_done) begin
        r_htrans <= HT_IDLE;
        r_cancel <= 1'b0;
      end else if (w_err_wait) begin
        // First ERROR cycle: withdraw any pending address beat immediately.
        r_htrans <= HT_IDLE;
        r_cancel <= 1'b1;
      end else if (w_accept) begin
        r_beats_left <= r_beats_left - 5'd1;
        if (w_last_beat) begin
          r_htrans <= HT_IDLE;
        end else begin
          r_htrans <= HT_SEQ;
          r_haddr  <= r_haddr + (r_inc ? (addr_w'(1) << r_size) : '0);
        end
      end
    end
  end

  assign bus.o_haddr       = r_haddr;
  assign bus.o_htrans      = r_htrans;
  assign bus.o_hsize       = r_hsize;
  assign bus.o_hburst      = r_hburst;
  assign bus.o_beat_done   = r_beat_done;
  assign bus.o_burst_done  = r_burst_done;
  assign bus.o_burst_beats = r_burst_beats;
  assign bus.o_error       = r_error;
endmodule

// File: tb/tb_dma_burst_sequencer.sv
// Directed self-checking bench for dma_burst_sequencer: single, INCR bursts with
// wait states, degrade-to-single cases, ERROR abandonment and mid-burst reset.
module tb_dma_burst_sequencer;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  dma_burst_sequencer_if #(.ndt_w(18), .addr_w(32)) tb_if ();

  dma_burst_sequencer #(.ndt_w(18), .addr_w(32)) dut (
    .i_clk    (clk),
    .i_nreset (nreset),
    .bus      (tb_if.master)
  );

  always #5 clk = ~clk;

  // Bus monitor: accepted address beats and event pulse totals.
  logic [31:0] mon_addr [64];
  logic [1:0]  mon_trans[64];
  int mon_n = 0;
  int cnt_beat = 0;
  int cnt_burst = 0;
  int cnt_err = 0;

  always @(negedge clk) begin
    if (nreset && tb_if.o_htrans != 2'b00 && tb_if.i_hready && mon_n < 64) begin
      mon_addr[mon_n]  = tb_if.o_haddr;
      mon_trans[mon_n] = tb_if.o_htrans;
      mon_n++;
    end
    if (tb_if.o_beat_done)  cnt_beat++;
    if (tb_if.o_burst_done) cnt_burst++;
    if (tb_if.o_error)      cnt_err++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input logic [31:0] a, input logic inc, input logic [1:0] sz,
                       input logic [1:0] bu, input logic [17:0] ndt);
    tb_if.i_addr      = a;
    tb_if.i_inc       = inc;
    tb_if.i_size      = sz;
    tb_if.i_burst     = bu;
    tb_if.i_ndt       = ndt;
    tb_if.i_master_en = 1'b1;
    tick();
    tb_if.i_master_en = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (tb_if.o_master_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_ready_in_time"}, tb_if.o_master_ready, 1'b1);
  endtask

  int bd0, bu0, er0, m0;
  logic [31:0] exp_a;

  initial begin
    tb_if.i_master_en = 1'b0;
    tb_if.i_addr      = '0;
    tb_if.i_inc       = 1'b1;
    tb_if.i_size      = 2'd2;
    tb_if.i_burst     = 2'd0;
    tb_if.i_ndt       = '0;
    tb_if.i_hready    = 1'b1;
    tb_if.i_hresp     = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_htrans", tb_if.o_htrans, 2'b00);
    check("rst_haddr", tb_if.o_haddr, 32'h0);
    check("rst_hsize", tb_if.o_hsize, 3'b000);
    check("rst_hburst", tb_if.o_hburst, 3'b000);
    check("rst_ready", tb_if.o_master_ready, 1'b1);
    check("rst_pulses", {tb_if.o_beat_done, tb_if.o_burst_done, tb_if.o_error}, 3'b000);
    check("rst_beats", tb_if.o_burst_beats, 5'd0);
    nreset = 1'b1;
    tick();

    // Word single, ndt=1, zero wait
    bd0 = cnt_beat; bu0 = cnt_burst; m0 = mon_n;
    grant(32'h100, 1'b1, 2'd2, 2'd0, 18'd1);
    check("s1_htrans", tb_if.o_htrans, 2'b10);
    check("s1_haddr", tb_if.o_haddr, 32'h100);
    check("s1_hburst", tb_if.o_hburst, 3'b000);
    check("s1_hsize", tb_if.o_hsize, 3'b010);
    check("s1_busy", tb_if.o_master_ready, 1'b0);
    tick();
    check("s1_last_htrans", tb_if.o_htrans, 2'b00);
    check("s1_last_busy", tb_if.o_master_ready, 1'b0);
    tick();
    check("s1_ready_3rd_edge", tb_if.o_master_ready, 1'b1);
    check("s1_burst_done", tb_if.o_burst_done, 1'b1);
    check("s1_burst_beats", tb_if.o_burst_beats, 5'd1);
    tick();
    check("s1_done_pulse_len", tb_if.o_burst_done, 1'b0);
    check("s1_beat_cnt", cnt_beat - bd0, 1);
    check("s1_burst_cnt", cnt_burst - bu0, 1);
    check("s1_addr_beats", mon_n - m0, 1);

    // INCR4 halfword with two wait states
    bd0 = cnt_beat; m0 = mon_n;
    grant(32'h200, 1'b1, 2'd1, 2'd1, 18'd10);
    check("i4_htrans0", tb_if.o_htrans, 2'b10);
    check("i4_hburst", tb_if.o_hburst, 3'b011);
    check("i4_hsize", tb_if.o_hsize, 3'b001);
    tick();
    check("i4_haddr1", tb_if.o_haddr, 32'h202);
    tb_if.i_hready = 1'b0;
    tick();
    check("i4_hold_w1", tb_if.o_haddr, 32'h202);
    check("i4_hold_trans_w1", tb_if.o_htrans, 2'b11);
    tick();
    check("i4_hold_w2", tb_if.o_haddr, 32'h202);
    tb_if.i_hready = 1'b1;
    wait_ready("i4");
    check("i4_burst_done", tb_if.o_burst_done, 1'b1);
    check("i4_burst_beats", tb_if.o_burst_beats, 5'd4);
    tick();
    check("i4_beat_cnt", cnt_beat - bd0, 4);
    check("i4_addr_beats", mon_n - m0, 4);
    for (int k = 0; k < 4; k++) begin
      exp_a = 32'h200 + 32'(2 * k);
      check($sformatf("i4_addr%0d", k), mon_addr[m0 + k], exp_a);
      check($sformatf("i4_trans%0d", k), mon_trans[m0 + k], (k == 0) ? 2'b10 : 2'b11);
    end

    // INCR8 with only 5 items left degrades to single
    m0 = mon_n;
    grant(32'h000, 1'b1, 2'd2, 2'd2, 18'd5);
    check("d8_hburst", tb_if.o_hburst, 3'b000);
    wait_ready("d8");
    check("d8_burst_beats", tb_if.o_burst_beats, 5'd1);
    tick();
    check("d8_addr_beats", mon_n - m0, 1);

    // INCR16 word at 0x3F0 crosses 1 KB
    grant(32'h3F0, 1'b1, 2'd2, 2'd3, 18'd100);
    check("x16_hburst", tb_if.o_hburst, 3'b000);
    wait_ready("x16");
    check("x16_burst_beats", tb_if.o_burst_beats, 5'd1);
    tick();

    // Fixed address INCR4 degrades to single
    grant(32'h40, 1'b0, 2'd2, 2'd1, 18'd100);
    check("fx_hburst", tb_if.o_hburst, 3'b000);
    check("fx_haddr", tb_if.o_haddr, 32'h40);
    wait_ready("fx");
    check("fx_burst_beats", tb_if.o_burst_beats, 5'd1);
    tick();

    // INCR4 ending exactly on the 1 KB boundary, size 3 treated as word
    m0 = mon_n;
    grant(32'h3F0, 1'b1, 2'd3, 2'd1, 18'd4);
    check("b4_hburst", tb_if.o_hburst, 3'b011);
    check("b4_hsize", tb_if.o_hsize, 3'b010);
    wait_ready("b4");
    check("b4_burst_beats", tb_if.o_burst_beats, 5'd4);
    tick();
    check("b4_addr3", mon_addr[m0 + 3], 32'h3FC);

    // ERROR response on the second beat of INCR4
    bd0 = cnt_beat; bu0 = cnt_burst; er0 = cnt_err;
    grant(32'h80, 1'b1, 2'd2, 2'd1, 18'd20);
    tick();
    check("er_haddr1", tb_if.o_haddr, 32'h84);
    tick();
    check("er_beat1_done", tb_if.o_beat_done, 1'b1);
    tb_if.i_hready = 1'b0;
    tb_if.i_hresp  = 1'b1;
    tick();
    check("er_cancel_htrans", tb_if.o_htrans, 2'b00);
    tb_if.i_hready = 1'b1;
    tick();
    tb_if.i_hresp = 1'b0;
    check("er_error_pulse", tb_if.o_error, 1'b1);
    check("er_ready", tb_if.o_master_ready, 1'b1);
    check("er_no_burst_done", tb_if.o_burst_done, 1'b0);
    tick(); tick();
    check("er_error_len", tb_if.o_error, 1'b0);
    check("er_beat_cnt", cnt_beat - bd0, 1);
    check("er_burst_cnt", cnt_burst - bu0, 0);
    check("er_err_cnt", cnt_err - er0, 1);

    // Reset during beat 3 of INCR8
    grant(32'h000, 1'b1, 2'd2, 2'd2, 18'd50);
    tick(); tick();
    check("rb_beat3_addr", tb_if.o_haddr, 32'h8);
    nreset = 1'b0;
    tick();
    bd0 = cnt_beat; bu0 = cnt_burst; er0 = cnt_err;
    check("rb_htrans", tb_if.o_htrans, 2'b00);
    check("rb_ready", tb_if.o_master_ready, 1'b1);
    check("rb_pulses", {tb_if.o_beat_done, tb_if.o_burst_done, tb_if.o_error}, 3'b000);
    nreset = 1'b1;
    tick(); tick(); tick();
    check("rb_quiet", (cnt_beat - bd0) + (cnt_burst - bu0) + (cnt_err - er0), 0);
    grant(32'h20, 1'b1, 2'd1, 2'd1, 18'd8);
    check("rb_new_nonseq", tb_if.o_htrans, 2'b10);
    check("rb_new_haddr", tb_if.o_haddr, 32'h20);
    wait_ready("rb");
    check("rb_new_beats", tb_if.o_burst_beats, 5'd4);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
